// File: rtl/layer1_relu_accumulator_if.sv
// Bundle of the pixel stream, weight-storage and activation ports of layer1_relu_accumulator.
// The slave modport is the accumulator side; the master modport is the side that drives its inputs.
interface layer1_relu_accumulator_if #(
    parameter int NODES       = 16,
    parameter int W_WIDTH     = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int OUT_WIDTH   = 16
);
    logic                         start;
    logic [PIXEL_WIDTH-1:0]       pixelIn;
    logic                         pixelValid;
    logic                         pixelReady;
    logic [9:0]                   NodeSelect;
    logic [NODES*W_WIDTH-1:0]     weightsIn;
    logic [NODES*OUT_WIDTH-1:0]   activations;
    logic                         outValid;
    logic                         outReady;
    logic                         busy;

    modport master (
        output start, pixelIn, pixelValid, weightsIn, outReady,
        input  pixelReady, NodeSelect, activations, outValid, busy
    );

    modport slave (
        input  start, pixelIn, pixelValid, weightsIn, outReady,
        output pixelReady, NodeSelect, activations, outValid, busy
    );
endinterface

// File: rtl/layer1_relu_accumulator.sv
// Layer-1 MAC: walks storage rows with the pixel stream, accumulates every weight lane in parallel,
// then applies ReLU with saturation and hands one activation vector to layer 2.
//
// state | meaning
// IDLE  | waiting for start; activations keep the last image's result
// ACCUM | accepting pixels, NodeSelect = pixel counter
// RELU  | one cycle converting accumulators to saturated activations
// DONE  | outValid held until layer 2 takes the vector
module layer1_relu_accumulator #(
    parameter int NODES       = 16,
    parameter int W_WIDTH     = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int INPUT_COUNT = 784,
    parameter int ACC_WIDTH   = 28,
    parameter int OUT_WIDTH   = 16
) (
    input logic                     clk,
    input logic                     reset,
    layer1_relu_accumulator_if.slave bus
);
    localparam int PROD_WIDTH = PIXEL_WIDTH + W_WIDTH + 1;
    localparam logic [9:0] LAST_ROW = 10'(INPUT_COUNT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, RELU, DONE} state_t;

    state_t                        state_q, state_d;
    logic [9:0]                    cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q [NODES];
    logic signed [ACC_WIDTH-1:0]   acc_d [NODES];
    logic [NODES*OUT_WIDTH-1:0]    act_q, act_d;
    logic                          out_valid_q, out_valid_d;
    logic                          pixel_ready_q, pixel_ready_d;
    logic                          busy_q, busy_d;
    logic                          accept;

    always_comb begin
        logic signed [PROD_WIDTH-1:0] pix_e;
        logic signed [PROD_WIDTH-1:0] w_e;
        logic signed [PROD_WIDTH-1:0] prod;
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_d       = act_q;
        out_valid_d = out_valid_q;
        pix_e       = {{W_WIDTH{1'b0}}, 1'b0, bus.pixelIn};
        w_e         = '0;
        prod        = '0;
        accept      = bus.pixelValid & pixel_ready_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    for (int k = 0; k < NODES; k++) acc_d[k] = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Product always fits PROD_WIDTH, so truncating the operand extension is exact.
                    for (int k = 0; k < NODES; k++) begin
                        w_e  = {{(PIXEL_WIDTH+1){bus.weightsIn[k*W_WIDTH+W_WIDTH-1]}},
                                bus.weightsIn[k*W_WIDTH +: W_WIDTH]};
                        prod = pix_e * w_e;
                        acc_d[k] = acc_q[k] +
                                   {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
                    end
                    if (cnt_q == LAST_ROW) state_d = RELU;
                    else                   cnt_d   = cnt_q + 10'd1;
                end
            end
            RELU: begin
                for (int k = 0; k < NODES; k++) begin
                    if (acc_q[k] < 0)             act_d[k*OUT_WIDTH +: OUT_WIDTH] = '0;
                    else if (acc_q[k] > SAT_MAX)  act_d[k*OUT_WIDTH +: OUT_WIDTH] = '1;
                    else act_d[k*OUT_WIDTH +: OUT_WIDTH] = acc_q[k][OUT_WIDTH-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pixel_ready_d = (state_d == ACCUM);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            act_q         <= '0;
            out_valid_q   <= 1'b0;
            pixel_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int k = 0; k < NODES; k++) acc_q[k] <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_q         <= act_d;
            out_valid_q   <= out_valid_d;
            pixel_ready_q <= pixel_ready_d;
            busy_q        <= busy_d;
            for (int k = 0; k < NODES; k++) acc_q[k] <= acc_d[k];
        end
    end

    assign bus.pixelReady  = pixel_ready_q;
    assign bus.NodeSelect  = pixel_ready_q ? cnt_q : 10'd0;
    assign bus.activations = act_q;
    assign bus.outValid    = out_valid_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_layer1_relu_accumulator.sv
// Directed bench for layer1_relu_accumulator: a combinational weight-storage model keyed on
// NodeSelect, scenario tasks with hand-computed expected activations.
module tb_layer1_relu_accumulator;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   wmode = 0;
    int   pmode = 0;

    layer1_relu_accumulator_if bus_if ();

    layer1_relu_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [7:0] wv;
        bus_if.weightsIn = '0;
        for (int k = 0; k < 16; k++) begin
            wv = 8'd0;
            case (wmode)
                1: wv = 8'd1;
                2: wv = (k == 0) ? 8'hFF : ((k == 1) ? 8'd2 : 8'd0);
                3: wv = (k == 3) ? {6'd0, bus_if.NodeSelect[1:0]} : 8'd0;
                default: wv = 8'd0;
            endcase
            bus_if.weightsIn[k*8 +: 8] = wv;
        end
    end

    function automatic logic [7:0] pix(input int r);
        case (pmode)
            1:       return 8'd1;
            2:       return 8'd255;
            3:       return 8'(r % 3);
            default: return 8'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_image();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    // Stimulus only: streams n pixels, optionally with random gaps and a stray start pulse.
    task automatic feed(input int n, input bit rnd, input int start_at,
                        output int got, output int ns_err);
        int  guard = 0;
        bit  acc_now;
        got    = 0;
        ns_err = 0;
        while (got < n && guard < 20000) begin
            bus_if.pixelValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_if.pixelIn    = pix(got);
            bus_if.start      = (got == start_at);
            #1;
            if (bus_if.pixelReady && bus_if.NodeSelect != 10'(got)) ns_err++;
            acc_now = bus_if.pixelValid && bus_if.pixelReady;
            tick();
            if (acc_now) got++;
            guard++;
        end
        bus_if.pixelValid = 1'b0;
        bus_if.start      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (bus_if.outValid !== 1'b0) begin
            miscompares++; $display("FAIL reset_outValid got %b want 0", bus_if.outValid);
        end
        vectors++;
        if (bus_if.pixelReady !== 1'b0) begin
            miscompares++; $display("FAIL reset_pixelReady got %b want 0", bus_if.pixelReady);
        end
        vectors++;
        if (bus_if.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy got %b want 0", bus_if.busy);
        end
        vectors++;
        if (bus_if.NodeSelect !== 10'd0) begin
            miscompares++; $display("FAIL reset_NodeSelect got %0d want 0", bus_if.NodeSelect);
        end
        vectors++;
        if (bus_if.activations !== 256'd0) begin
            miscompares++; $display("FAIL reset_activations got %h want 0", bus_if.activations);
        end
    endtask

    task automatic test_all_ones();
        int got, ns_err;
        wmode = 1;
        pmode = 1;
        begin_image();
        vectors++;
        if (bus_if.busy !== 1'b1 || bus_if.pixelReady !== 1'b1) begin
            miscompares++;
            $display("FAIL ones_enter_accum got busy=%b ready=%b want 1 1", bus_if.busy, bus_if.pixelReady);
        end
        feed(784, 1'b0, -1, got, ns_err);
        vectors++;
        if (got !== 784 || ns_err !== 0) begin
            miscompares++; $display("FAIL ones_stream got accepted=%0d nserr=%0d want 784 0", got, ns_err);
        end
        vectors++;
        if (bus_if.outValid !== 1'b0 || bus_if.pixelReady !== 1'b0) begin
            miscompares++;
            $display("FAIL ones_latency1 got outValid=%b ready=%b want 0 0", bus_if.outValid, bus_if.pixelReady);
        end
        tick();
        vectors++;
        if (bus_if.outValid !== 1'b1) begin
            miscompares++; $display("FAIL ones_latency2 got outValid=%b want 1", bus_if.outValid);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (bus_if.activations[k*16 +: 16] !== 16'h0310) begin
                miscompares++;
                $display("FAIL ones_lane%0d got %h want 0310", k, bus_if.activations[k*16 +: 16]);
            end
        end
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
        vectors++;
        if (bus_if.outValid !== 1'b0 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ones_release got outValid=%b busy=%b want 0 0", bus_if.outValid, bus_if.busy);
        end
    endtask

    task automatic test_relu_sat();
        int got, ns_err;
        logic [15:0] exp;
        wmode = 2;
        pmode = 2;
        begin_image();
        feed(784, 1'b0, -1, got, ns_err);
        tick();
        vectors++;
        if (bus_if.outValid !== 1'b1) begin
            miscompares++; $display("FAIL sat_outValid got %b want 1", bus_if.outValid);
        end
        for (int k = 0; k < 16; k++) begin
            exp = (k == 1) ? 16'hFFFF : 16'h0000;
            vectors++;
            if (bus_if.activations[k*16 +: 16] !== exp) begin
                miscompares++;
                $display("FAIL sat_lane%0d got %h want %h", k, bus_if.activations[k*16 +: 16], exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [255:0] exp;
        exp = '0;
        exp[31:16] = 16'hFFFF;
        bus_if.outReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (bus_if.outValid !== 1'b1 || bus_if.activations !== exp) begin
                miscompares++;
                $display("FAIL hold_cycle%0d got outValid=%b act=%h want 1 %h", i, bus_if.outValid,
                         bus_if.activations, exp);
            end
        end
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
        vectors++;
        if (bus_if.outValid !== 1'b0 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release got outValid=%b busy=%b want 0 0", bus_if.outValid, bus_if.busy);
        end
        vectors++;
        if (bus_if.activations !== exp) begin
            miscompares++; $display("FAIL hold_retain got %h want %h", bus_if.activations, exp);
        end
    endtask

    task automatic test_random_gaps();
        int got, ns_err;
        int ref3 = 0;
        for (int r = 0; r < 784; r++) ref3 += (r % 4) * (r % 3);
        wmode = 3;
        pmode = 3;
        begin_image();
        feed(784, 1'b1, -1, got, ns_err);
        vectors++;
        if (got !== 784 || ns_err !== 0) begin
            miscompares++; $display("FAIL gaps_stream got accepted=%0d nserr=%0d want 784 0", got, ns_err);
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (bus_if.activations[k*16 +: 16] !== ((k == 3) ? 16'(ref3) : 16'd0)) begin
                miscompares++;
                $display("FAIL gaps_lane%0d got %0d want %0d", k, bus_if.activations[k*16 +: 16],
                         (k == 3) ? ref3 : 0);
            end
        end
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        int got, ns_err;
        wmode = 1;
        pmode = 1;
        begin_image();
        feed(400, 1'b0, -1, got, ns_err);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (bus_if.busy !== 1'b0 || bus_if.outValid !== 1'b0 || bus_if.activations !== 256'd0) begin
            miscompares++;
            $display("FAIL midreset_state got busy=%b outValid=%b act=%h want 0 0 0", bus_if.busy,
                     bus_if.outValid, bus_if.activations);
        end
        pmode = 0;
        begin_image();
        feed(784, 1'b0, -1, got, ns_err);
        tick();
        vectors++;
        if (bus_if.outValid !== 1'b1 || bus_if.activations !== 256'd0) begin
            miscompares++;
            $display("FAIL midreset_zero got outValid=%b act=%h want 1 0", bus_if.outValid,
                     bus_if.activations);
        end
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
    endtask

    task automatic test_start_ignored();
        int got, ns_err;
        wmode = 1;
        pmode = 1;
        begin_image();
        feed(784, 1'b0, 100, got, ns_err);
        vectors++;
        if (got !== 784 || ns_err !== 0) begin
            miscompares++; $display("FAIL ignstart_stream got accepted=%0d nserr=%0d want 784 0", got, ns_err);
        end
        tick();
        bus_if.start = 1'b1;
        tick();
        vectors++;
        if (bus_if.outValid !== 1'b1 || bus_if.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignstart_done got outValid=%b busy=%b want 1 1", bus_if.outValid, bus_if.busy);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (bus_if.activations[k*16 +: 16] !== 16'd784) begin
                miscompares++;
                $display("FAIL ignstart_lane%0d got %0d want 784", k, bus_if.activations[k*16 +: 16]);
            end
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int got, ns_err;
        bus_if.start    = 1'b1;
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
        vectors++;
        if (bus_if.busy !== 1'b0 || bus_if.outValid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle got busy=%b outValid=%b want 0 0", bus_if.busy, bus_if.outValid);
        end
        tick();
        bus_if.start = 1'b0;
        vectors++;
        if (bus_if.busy !== 1'b1 || bus_if.pixelReady !== 1'b1 || bus_if.NodeSelect !== 10'd0) begin
            miscompares++;
            $display("FAIL b2b_restart got busy=%b ready=%b ns=%0d want 1 1 0", bus_if.busy,
                     bus_if.pixelReady, bus_if.NodeSelect);
        end
        wmode = 2;
        pmode = 1;
        feed(784, 1'b0, -1, got, ns_err);
        tick();
        vectors++;
        if (bus_if.activations[15:0] !== 16'd0 || bus_if.activations[31:16] !== 16'd1568) begin
            miscompares++;
            $display("FAIL b2b_result got lane0=%0d lane1=%0d want 0 1568", bus_if.activations[15:0],
                     bus_if.activations[31:16]);
        end
        bus_if.outReady = 1'b1;
        tick();
        bus_if.outReady = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.pixelIn    = 8'd0;
        bus_if.pixelValid = 1'b0;
        bus_if.outReady   = 1'b0;
        test_reset();
        test_all_ones();
        test_relu_sat();
        test_hold();
        test_random_gaps();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
